// File: rtl/div_pkg.sv
// Shared types and constants for the divider-result UART transmitter.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } div_state_t;

  localparam int Q_W = 4;
  localparam int R_W = 4;

  localparam logic [Q_W+R_W-1:0] DIV0_CODE_DEFAULT = 8'hEE;

endpackage

// File: rtl/div_baud_tick.sv
// Bit-period counter: runs 0..CLK_DIV-1 while enabled, pulses o_tick on the
// final count and wraps; i_clr parks it at zero.
module div_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int               CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/div_result_uart_tx.sv
// Serialises packed divider results {quotient, remainder} as UART frames.
// Define DIV_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module div_result_uart_tx
  import div_pkg::*;
#(
  parameter int                DATA_W    = Q_W + R_W,
  parameter int                CLK_DIV   = 4,
  parameter logic [DATA_W-1:0] DIV0_CODE = DIV0_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_div0,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_o,
  output logic              busy,
  output logic              tx_done,
  output logic [7:0]        sent_count,
  output logic [2:0]        o_dbg_state
);

  // Handshake: a result transfers on any clk edge where in_valid && in_ready;
  // in_ready depends only on ena and the holding register, never on in_valid.

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  div_state_t        r_state;
  div_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_tx;
  logic [7:0]        r_sent_count;
`ifdef DIV_UART_PARITY_EN
  logic              r_parity;
`endif

  logic w_tick;
  logic w_accept;
  logic w_last_bit;
  logic w_load;
  logic w_shift;
  logic w_idx_inc;
  logic w_frame_end;
  logic w_tx_nxt;

  div_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (ena && (r_state != IDLE)),
    .i_clr  (r_state == IDLE),
    .o_tick (w_tick)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_last_bit  = (r_idx == IDX_W'(DATA_W - 1));
  assign w_frame_end = (r_state == STOP) && w_tick;

  assign in_ready    = ena && !r_hold_full;
  assign tx_o        = r_tx;
  assign busy        = (r_state != IDLE);
  assign tx_done     = w_frame_end;
  assign sent_count  = r_sent_count;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (r_hold_full) w_state_nxt = START;
      START: if (w_tick) w_state_nxt = DATA;
`ifdef DIV_UART_PARITY_EN
      DATA:   if (w_tick && w_last_bit) w_state_nxt = PARITY;
      PARITY: if (w_tick) w_state_nxt = STOP;
`else
      DATA:   if (w_tick && w_last_bit) w_state_nxt = STOP;
`endif
      // A result waiting at the end of the stop bit starts with no idle gap.
      STOP:  if (w_tick) w_state_nxt = r_hold_full ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_idx_inc = 1'b0;
    w_tx_nxt  = r_tx;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load   = 1'b1;
          w_tx_nxt = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_shift  = 1'b1;
          w_tx_nxt = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (w_last_bit) begin
`ifdef DIV_UART_PARITY_EN
            w_tx_nxt = r_parity;
`else
            w_tx_nxt = 1'b1;
`endif
          end else begin
            w_shift   = 1'b1;
            w_idx_inc = 1'b1;
            w_tx_nxt  = r_shift[0];
          end
        end
      end
`ifdef DIV_UART_PARITY_EN
      PARITY: begin
        if (w_tick) w_tx_nxt = 1'b1;
      end
`endif
      STOP: begin
        if (w_tick) begin
          if (r_hold_full) begin
            w_load   = 1'b1;
            w_tx_nxt = 1'b0;
          end else begin
            w_tx_nxt = 1'b1;
          end
        end
      end
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_idx        <= '0;
      r_tx         <= 1'b1;
      r_sent_count <= '0;
`ifdef DIV_UART_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else if (ena) begin
      // Accept needs an empty hold and load needs a full one, so they never coincide.
      if (w_accept) begin
        r_hold      <= in_div0 ? DIV0_CODE : in_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_load) begin
        r_shift <= r_hold;
        r_idx   <= '0;
`ifdef DIV_UART_PARITY_EN
        r_parity <= ^r_hold;
`endif
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
      end
      if (w_idx_inc) r_idx <= r_idx + 1'b1;
      r_tx <= w_tx_nxt;
      if (w_frame_end) r_sent_count <= r_sent_count + 1'b1;
    end
  end

endmodule
